// File: rtl/descrack_result_collector_if.sv
// descrack_result_collector_if: stream input and host readback bundle for the result collector
interface descrack_result_collector_if;
  logic        fsl_rst_i;
  logic [31:0] fsl_data_i;
  logic        fsl_valid_i;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [8:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_stat;
  logic [31:0] rd_ts;
  modport master (
    output fsl_rst_i, fsl_data_i, fsl_valid_i, rd_en, clr_stat,
    input  rd_data, rd_valid, count, overflow, drop_cnt, rd_ts
  );
  modport slave (
    input  fsl_rst_i, fsl_data_i, fsl_valid_i, rd_en, clr_stat,
    output rd_data, rd_valid, count, overflow, drop_cnt, rd_ts
  );
endinterface

// File: rtl/descrack_result_collector.sv
// descrack_result_collector: parses 3-word key-hit packets into a first-word-fall-through FIFO.
// Define DESCRACK_RESULT_TIMESTAMP_EN to store a header-time cycle stamp with each entry.
module descrack_result_collector #(
  parameter int         DEPTH   = 16,
  parameter logic [7:0] HDR_TAG = 8'hA5
) (
  input logic clk,
  input logic rst_n,
  descrack_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, KEY_HI, KEY_LO} state_t;
  state_t      r_state, w_next;
  logic        w_acc, w_hdr, w_junk, w_hi, w_lo;
  logic [7:0]  r_core;
  logic [23:0] r_key_hi;
  logic        r_push;
  logic [63:0] r_entry;
  logic [63:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [8:0]  r_count;
  logic [63:0] r_rd_data;
  logic        r_ovf;
  logic [15:0] r_drop;
  logic        w_full, w_pop, w_wr, w_ovf, w_head_ld, w_head_mem;
  logic [16:0] w_drop_sum;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb
    w_next = bus.fsl_rst_i ? IDLE :
             !bus.fsl_valid_i ? r_state :
             r_state == IDLE ? (bus.fsl_data_i[31:24] == HDR_TAG ? KEY_HI : IDLE) :
             r_state == KEY_HI ? KEY_LO : IDLE;

  always_comb begin
    w_acc  = bus.fsl_valid_i && !bus.fsl_rst_i;
    w_hdr  = w_acc && r_state == IDLE && bus.fsl_data_i[31:24] == HDR_TAG;
    w_junk = w_acc && r_state == IDLE && bus.fsl_data_i[31:24] != HDR_TAG;
    w_hi   = w_acc && r_state == KEY_HI;
    w_lo   = w_acc && r_state == KEY_LO;
  end

  // The completed entry is staged one cycle, so the push lands on the edge after the last word.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_core   <= '0;
      r_key_hi <= '0;
      r_entry  <= '0;
      r_push   <= 1'b0;
    end else begin
      if (w_hdr) r_core <= bus.fsl_data_i[23:16];
      if (w_hi) r_key_hi <= bus.fsl_data_i[23:0];
      if (w_lo) r_entry <= {r_core, r_key_hi, bus.fsl_data_i};
      r_push <= w_lo;
    end

  always_comb begin
    w_full     = r_count == 9'(DEPTH);
    w_pop      = bus.rd_en && r_count != '0;
    w_wr       = r_push && (!w_full || w_pop);
    w_ovf      = r_push && w_full && !w_pop;
    w_head_mem = w_pop && r_count > 9'd1;
    w_head_ld  = w_head_mem || (w_wr && (w_pop || r_count == '0));
    w_drop_sum = {1'b0, r_drop} + 17'(w_junk) + 17'(w_ovf);
  end

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= r_entry;

  // rd_data is a registered head copy so it resets to 0 and holds once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_ovf     <= 1'b0;
      r_drop    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + 9'(w_wr) - 9'(w_pop);
      if (w_head_ld) r_rd_data <= w_head_mem ? r_mem[r_rd_ptr + AW'(1)] : r_entry;
      r_ovf  <= !bus.clr_stat && (r_ovf || w_ovf);
      r_drop <= bus.clr_stat ? '0 : w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_count != '0;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
  assign bus.drop_cnt = r_drop;

`ifdef DESCRACK_RESULT_TIMESTAMP_EN
  logic [31:0] r_cyc, r_ts_hdr, r_ts_entry, r_rd_ts;
  logic [31:0] r_ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cyc      <= '0;
      r_ts_hdr   <= '0;
      r_ts_entry <= '0;
      r_rd_ts    <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_hdr) r_ts_hdr <= r_cyc;
      if (w_lo) r_ts_entry <= r_ts_hdr;
      if (w_head_ld) r_rd_ts <= w_head_mem ? r_ts_mem[r_rd_ptr + AW'(1)] : r_ts_entry;
    end

  always_ff @(posedge clk)
    if (w_wr) r_ts_mem[r_wr_ptr] <= r_ts_entry;

  assign bus.rd_ts = r_rd_ts;
`else
  assign bus.rd_ts = '0;
`endif
endmodule

// File: tb/tb_descrack_result_collector.sv
// tb_descrack_result_collector: table vectors, corner sequences and random traffic against a packet-level model
module tb_descrack_result_collector;
  localparam int DEPTH = 16;
`ifdef DESCRACK_RESULT_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  descrack_result_collector_if bus();
  descrack_result_collector #(.DEPTH(DEPTH), .HDR_TAG(8'hA5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: queue of {ts, entry}; a finished packet reaches the queue one edge after its last word.
  logic [95:0] q[$];
  logic [95:0] mlast, pend_e;
  bit          pend, movf;
  int          nw, mdrop;
  logic [7:0]  mcore;
  logic [23:0] mkhi;
  logic [31:0] mts, mcyc;

  typedef struct {
    logic [31:0] d;
    logic        v, r, c;
    logic        ev;
    logic [8:0]  ecnt;
    logic [63:0] edata;
    logic [15:0] edrop;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    mlast = '0; pend_e = '0; pend = 0; movf = 0; nw = 0; mdrop = 0;
    mcore = '0; mkhi = '0; mts = '0; mcyc = '0;
  endfunction

  task automatic model_edge();
    bit pop_ok, push_ok, npend;
    logic [95:0] ne;
    int drops;
    pop_ok = bus.rd_en && q.size() > 0;
    push_ok = 0; npend = 0; ne = '0; drops = 0;
    if (pend) begin
      if (q.size() < DEPTH || pop_ok) push_ok = 1;
      else begin movf = 1; drops++; end
    end
    if (bus.fsl_rst_i) nw = 0;
    else if (bus.fsl_valid_i) begin
      if (nw == 0) begin
        if (bus.fsl_data_i[31:24] == 8'hA5) begin mcore = bus.fsl_data_i[23:16]; mts = mcyc; nw = 1; end
        else drops++;
      end else if (nw == 1) begin mkhi = bus.fsl_data_i[23:0]; nw = 2; end
      else begin npend = 1; ne = {mts, mcore, mkhi, bus.fsl_data_i}; nw = 0; end
    end
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(pend_e);
    pend = npend; pend_e = ne;
    if (bus.clr_stat) begin movf = 0; mdrop = 0; end
    else mdrop = (mdrop + drops > 65535) ? 65535 : mdrop + drops;
    mcyc++;
    if (q.size() > 0) mlast = q[0];
  endtask

  task automatic check_all();
    chk("rd_valid", bus.rd_valid, q.size() != 0);
    chk("count", bus.count, q.size());
    chk("rd_data", bus.rd_data, mlast[63:0]);
    chk("overflow", bus.overflow, movf);
    chk("drop_cnt", bus.drop_cnt, mdrop);
    chk("rd_ts", bus.rd_ts, TS ? mlast[95:64] : 32'd0);
  endtask

  task automatic step(input logic [31:0] d, input logic v, input logic f, input logic r, input logic c);
    bus.fsl_data_i = d; bus.fsl_valid_i = v; bus.fsl_rst_i = f; bus.rd_en = r; bus.clr_stat = c;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle(); step(32'h0, 0, 0, 0, 0); endtask
  task automatic pop(); step(32'h0, 0, 0, 1, 0); endtask

  task automatic send_pkt(input int i);
    step({8'hA5, 8'(i), 16'h0}, 1, 0, 0, 0);
    step(32'(i), 1, 0, 0, 0);
    step(32'hC0DE0000 | 32'(i), 1, 0, 0, 0);
  endtask

  function automatic logic [63:0] pkt(input int i);
    return {8'(i), 24'(i), 32'hC0DE0000 | 32'(i)};
  endfunction

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst rd_valid", bus.rd_valid, 0);
    chk("rst count", bus.count, 0);
    chk("rst overflow", bus.overflow, 0);
    chk("rst drop_cnt", bus.drop_cnt, 0);
    chk("rst rd_data", bus.rd_data, 0);
    chk("rst rd_ts", bus.rd_ts, 0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] h1, h2, h3;
    h1 = 64'h03ABCDEF12345678;
    h2 = 64'h071234560000BEEF;
    h3 = 64'h01000001A5A5A5A5;
    tbl[0]  = '{32'hA5030000, 1, 0, 0, 0, 0, 64'h0, 0};
    tbl[1]  = '{32'h00ABCDEF, 1, 0, 0, 0, 0, 64'h0, 0};
    tbl[2]  = '{32'h12345678, 1, 0, 0, 0, 0, 64'h0, 0};
    tbl[3]  = '{32'h0,        0, 0, 0, 1, 1, h1, 0};
    tbl[4]  = '{32'h0,        0, 1, 0, 0, 0, h1, 0};
    tbl[5]  = '{32'h11000000, 1, 0, 0, 0, 0, h1, 1};
    tbl[6]  = '{32'h22000000, 1, 0, 0, 0, 0, h1, 2};
    tbl[7]  = '{32'h33000000, 1, 0, 0, 0, 0, h1, 3};
    tbl[8]  = '{32'h5A000000, 1, 0, 0, 0, 0, h1, 4};
    tbl[9]  = '{32'hFF000000, 1, 0, 0, 0, 0, h1, 5};
    tbl[10] = '{32'hA507FFFF, 1, 0, 0, 0, 0, h1, 5};
    tbl[11] = '{32'hAA123456, 1, 0, 0, 0, 0, h1, 5};
    tbl[12] = '{32'h0000BEEF, 1, 0, 0, 0, 0, h1, 5};
    tbl[13] = '{32'h0,        0, 0, 0, 1, 1, h2, 5};
    tbl[14] = '{32'hA5010000, 1, 0, 0, 1, 1, h2, 5};
    tbl[15] = '{32'hA5000001, 1, 0, 0, 1, 1, h2, 5};
    tbl[16] = '{32'hA5A5A5A5, 1, 0, 0, 1, 1, h2, 5};
    tbl[17] = '{32'h0,        0, 0, 0, 1, 2, h2, 5};
    tbl[18] = '{32'h0,        0, 1, 0, 1, 1, h3, 5};
    tbl[19] = '{32'h0,        0, 1, 0, 0, 0, h3, 5};
    tbl[20] = '{32'h0,        0, 0, 1, 0, 0, h3, 0};

    bus.fsl_data_i = '0; bus.fsl_valid_i = 0; bus.fsl_rst_i = 0; bus.rd_en = 0; bus.clr_stat = 0;
    async_reset();

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].d, tbl[i].v, 0, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d rd_valid", i), bus.rd_valid, tbl[i].ev);
      chk($sformatf("tbl%0d count", i), bus.count, tbl[i].ecnt);
      chk($sformatf("tbl%0d rd_data", i), bus.rd_data, tbl[i].edata);
      chk($sformatf("tbl%0d drop_cnt", i), bus.drop_cnt, tbl[i].edrop);
    end

    for (int i = 1; i <= 17; i++) send_pkt(i);
    idle();
    chk("full count", bus.count, DEPTH);
    chk("full overflow", bus.overflow, 1);
    chk("full drop_cnt", bus.drop_cnt, 1);
    chk("full head", bus.rd_data, pkt(1));
    send_pkt(18);
    pop();
    chk("full push+pop count", bus.count, DEPTH);
    chk("full push+pop head", bus.rd_data, pkt(2));
    chk("full push+pop drop_cnt", bus.drop_cnt, 1);
    step(32'h0, 0, 0, 0, 1);
    chk("clr overflow", bus.overflow, 0);
    chk("clr drop_cnt", bus.drop_cnt, 0);
    chk("clr count", bus.count, DEPTH);
    for (int i = 0; i < DEPTH; i++) pop();
    send_pkt(19);
    pop();
    chk("empty push+pop count", bus.count, 1);
    chk("empty push+pop head", bus.rd_data, pkt(19));
    pop();

    step(32'hA5090000, 1, 0, 0, 0);
    step(32'h0, 0, 1, 0, 0);
    step(32'h00000011, 1, 0, 0, 0);
    send_pkt(10);
    idle();
    chk("srst drop_cnt", bus.drop_cnt, 1);
    chk("srst count", bus.count, 1);
    chk("srst head", bus.rd_data, pkt(10));
    pop();

    for (int i = 1; i <= 3; i++) send_pkt(20 + i);
    idle();
    chk("pre-reset count", bus.count, 3);
    step(32'hA5770000, 1, 0, 0, 0);
    step(32'h00000077, 1, 0, 0, 0);
    async_reset();
    send_pkt(5);
    idle();
    chk("post-reset count", bus.count, 1);
    chk("post-reset head", bus.rd_data, pkt(5));

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] d;
      d = $urandom_range(0, 2) == 0 ? $urandom() : {8'hA5, 24'($urandom())};
      step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    end

    if (TS) begin
      async_reset();
      while (mcyc != 100) idle();
      send_pkt(1);
      while (mcyc != 250) idle();
      send_pkt(2);
      idle();
      chk("ts first", bus.rd_ts, 100);
      pop();
      chk("ts second", bus.rd_ts, 250);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/descrack_result_collector.md
# descrack_result_collector

Terminal stage of the DES-crack FSL stream. Consumes the 32-bit word stream leaving the last core of a region chain, parses 3-word key-hit packets, and buffers each hit in a FIFO for host readback. Discards non-packet traffic, such as pass-through configuration words, and reports drops and overflows to the host.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- HDR_TAG, 8'hA5: value of header bits [31:24] that marks a key-hit packet.

Ports:
- clk  in  1  single clock for the whole block (stream and host side).
- rst_n  in  1  asynchronous, active-low reset.
- fsl_rst_i  in  1  stream reset from the chain; synchronous, active-high; resynchronises the parser only.
- fsl_data_i  in  32  stream word.
- fsl_valid_i  in  1  word qualifier; no backpressure exists.
- rd_en  in  1  pop the head entry; ignored when empty.
- rd_data  out  64  head entry: {core[7:0], key[55:0]}.
- rd_valid  out  1  FIFO non-empty.
- count  out  9  occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a hit was lost to a full FIFO.
- drop_cnt  out  16  saturating count of discarded words and packets.
- clr_stat  in  1  clears overflow and drop_cnt.
- rd_ts  out  32  timestamp of the head entry (macro only; see Configuration).

## Operation
- Packet format:
  - Header: [31:24]=HDR_TAG, [23:16]=core id, [15:0] ignored.
  - Word 2: [23:0]=key[55:32], [31:24] ignored.
  - Word 3: key[31:0].
- Parser FSM, advancing only on cycles with fsl_valid_i=1:
  - IDLE: a header word goes to KEY_HI and latches the core id. Any other word is discarded and drop_cnt increments.
  - KEY_HI: latches key[55:32], goes to KEY_LO.
  - KEY_LO: latches key[31:0], issues a push, returns to IDLE.
  - Words in KEY_HI and KEY_LO are taken as payload even when they carry HDR_TAG.
- fsl_rst_i=1 forces IDLE the same cycle and takes priority over fsl_valid_i. The partial packet is abandoned; it does not count as a drop.
- FIFO:
  - First-word-fall-through. rd_data and rd_ts show the head entry whenever rd_valid=1. When empty, rd_data holds its last value.
  - Push when full with no pop in the same cycle: the entry is discarded, overflow is set, and drop_cnt increments.
  - Push and pop in the same cycle when full: both are accepted and count stays at DEPTH.
  - Push and pop in the same cycle when empty: the push is accepted, the pop is ignored, and count becomes 1.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately so full and empty are distinguished.
- drop_cnt saturates at 16'hFFFF.
- clr_stat: if it coincides with a drop, clear wins and the drop is lost. clr_stat does not affect FIFO contents.
- Reset (rst_n=0): FSM goes to IDLE, pointers and count go to 0. Outputs: rd_valid=0, count=0, overflow=0, drop_cnt=0, rd_data=0, rd_ts=0. Asserting rst_n mid-packet discards the packet.

## Timing
- Header, KEY_HI and KEY_LO words may arrive on consecutive cycles or with any number of idle cycles between them.
- The third word is accepted at edge N. The push occurs at edge N+1. rd_valid and count update at edge N+1 and are visible after it.
- A pop at edge M presents the next entry after edge M. count decrements at edge M.
- Sustained rate: one packet every 3 cycles, which the FIFO absorbs without loss as long as the host pops at that rate.
- overflow and drop_cnt update at the edge that performs the drop.

## Configuration
- DESCRACK_RESULT_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter, reset to 0, wraps at 2^32.
  - Its value is sampled when the header is accepted and stored alongside the entry.
  - rd_ts presents the stored timestamp of the head entry.
- Not defined: the counter and timestamp storage are absent, and rd_ts is tied to 0.

## Test plan
- Single packet: send A5_03_0000, 00ABCDEF, 12345678 on consecutive cycles. Two cycles after the last word: rd_valid=1, rd_data=64'h03ABCDEF12345678, count=1. Pulse rd_en, then rd_valid=0 and count=0.
- Garbage filtering: send 5 words with [31:24]≠A5, then one valid packet. drop_cnt=5 and exactly one entry is queued.
- Overflow (DEPTH=16): send 17 packets with no reads. count=16, overflow=1, drop_cnt=1, head entry is packet 1. Push and pop in the same cycle at full: count stays 16. Pulse clr_stat: overflow=0, drop_cnt=0.
- Stream reset: send a header, pulse fsl_rst_i, then send 00000011 followed by a full packet. drop_cnt=1 (word 00000011 dropped in IDLE). Only the full packet is queued.
- Async reset: assert rst_n mid-packet with 3 entries queued. All outputs read 0 immediately. A subsequent packet queues normally with count=1.
- With DESCRACK_RESULT_TIMESTAMP_EN: headers accepted at counter values 100 and 250. rd_ts reads 100, then 250 after one pop.
